fft16_input_loader: RTL and testbench
=====================================

Name: fft16_input_loader

Overview:
- Streaming front end of the 16-point FFT. Sits directly upstream of the first butterfly stage.
- Accepts one complex sample per cycle over a valid/ready handshake and gathers 16 samples into a frame.
- Presents each frame as flattened real/imag buses in the layout the first stage consumes.
- Ping-pong buffering lets frame k+1 be collected while frame k is held for downstream.

Parameters:
- DATA_WIDTH, 20, width of each real/imag sample (signed Q1.19).
- N_POINTS, 16, samples per frame. Fixed; the butterfly stages are hard-wired to 16.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample present on in_real/in_imag.
- in_ready  out  1  loader can accept a sample this cycle.
- in_real  in  DATA_WIDTH  signed sample, real part.
- in_imag  in  DATA_WIDTH  signed sample, imaginary part.
- in_sof  in  1  start-of-frame marker, qualified by in_valid.
- frame_valid  out  1  complete frame held on x_out_flat_*.
- frame_ready  in  1  downstream takes the frame this cycle.
- x_out_flat_real  out  DATA_WIDTH*16  frame, real parts.
- x_out_flat_imag  out  DATA_WIDTH*16  frame, imaginary parts.
- err_misalign  out  1  one-cycle pulse: in_sof seen mid-frame.

Behaviour:
- Bus layout: sample n occupies slice [DATA_WIDTH*(16-n)-1 -: DATA_WIDTH], so sample 0 is at the MSBs. This applies to both buses.
- State: two banks (0/1), full[1:0], wr_bank, wr_idx[3:0], rd_bank.
- Reset (sync, rst=1 at a clock edge):
  - full=0, wr_bank=0, rd_bank=0, wr_idx=0.
  - frame_valid=0, err_misalign=0, output buses all zero.
  - in_ready is forced 0 while rst is high.
  - A partial frame in progress is discarded.
- in_ready = !rst && !full[wr_bank]. It is combinational from registered state.
- Accept occurs when in_valid && in_ready.
  - On accept, the sample is written to bank[wr_bank][wr_idx] and wr_idx increments.
  - When wr_idx==15 on accept: full[wr_bank]<=1, wr_bank toggles, wr_idx<=0.
- Misalignment: accept with in_sof=1 and wr_idx!=0.
  - The partial frame is abandoned.
  - The sample is written at index 0 and wr_idx<=1.
  - err_misalign pulses high on the next cycle.
  - in_sof with wr_idx==0 is normal and gives no error.
  - in_sof is not required; frames self-align on a count of 16.
- Output side:
  - frame_valid = full[rd_bank], registered state.
  - x_out_flat_* are driven from bank[rd_bank].
  - On frame_valid && frame_ready: full[rd_bank]<=0 and rd_bank toggles.
  - While frame_valid && !frame_ready, the buses and frame_valid hold stable.
- Latency: 16th sample accepted at edge N gives frame_valid=1 after edge N, i.e. visible in cycle N+1.
- Simultaneous events:
  - Completion into one bank and release of the other in the same cycle are both honoured.
  - The freed bank becomes writable the following cycle.
- Throughput:
  - With frame_ready tied 1, in_ready never drops, giving 1 sample/cycle sustained.
  - When both banks are full, in_ready=0 until one frame is released.
- Arithmetic: none. Samples are stored bit-exact, with no scaling or saturation.
- Bank contents are not cleared on release. Only the full flags gate validity.

Decomposition:
- Shared package fft16_pkg holds:
  - N_POINTS=16 and LOG2_N=4.
  - Default DATA_WIDTH=20.
  - Q19 constants (ONE_Q19=20'sh7FFFF, ZERO=0), reused by the round_* stages.
  - A slice-index helper function mapping sample n to its bus offset.
- Sub-module fft16_frame_bank: one 16-entry register bank.
  - Inputs: write enable, 4-bit index, real/imag data.
  - Outputs: the flattened 16-sample real/imag buses.
  - Instantiated twice. The top module holds the control logic and a 2:1 output mux.

Test Plan:
- Reset then stream samples real=n, imag=-n for n=0..15, with in_valid=1, in_sof on n=0 and frame_ready=1.
  - Expect frame_valid in the cycle after n=15 is accepted.
  - Expect x_out_flat_real[319:300]=0 and x_out_flat_real[19:0]=15.
  - Expect x_out_flat_imag[19:0]=-15 (20'hFFFF1).
- Hold frame_ready=0 and stream 40 samples.
  - Expect in_ready=0 after sample 32.
  - Expect frame 0 (samples 0..15) to stay stable.
  - Raise frame_ready for one cycle: expect frame 1 (samples 16..31) to be presented next and in_ready to return to 1.
- Send 5 samples, then in_sof with real=100.
  - Expect err_misalign to pulse once.
  - After 15 more samples, expect a frame whose sample 0 is 100.
- Stream continuously for 64 samples with frame_ready=1.
  - Expect in_ready high throughout.
  - Expect 4 frames, each with frame_valid high for exactly one cycle.
- Assert rst after 7 samples.
  - Expect in_ready=0 and frame_valid=0 during reset, and outputs zero.
  - The next 16 samples form a clean frame with no error pulse.
- Complete bank 1 in the same cycle bank 0 is released.
  - Expect frame_valid to stay 1 continuously.
  - Expect the bus to switch to bank 1's data with no gap.

Source files
------------

// File: rtl/fft16_pkg.sv
// Shared definitions for the 16-point FFT datapath: frame geometry, Q1.19
// constants and the mapping from sample number to flattened-bus offset.
package fft16_pkg;

  localparam int N_POINTS           = 16;
  localparam int LOG2_N             = 4;
  localparam int DEFAULT_DATA_WIDTH = 20;

  localparam logic [LOG2_N-1:0] LAST_IDX = 4'd15;

  localparam logic signed [DEFAULT_DATA_WIDTH-1:0] ONE_Q19  = 20'sh7FFFF;
  localparam logic signed [DEFAULT_DATA_WIDTH-1:0] ZERO_Q19 = 20'sh00000;

  // Sample 0 sits at the MSBs, so sample n starts (15-n) slots above bit 0.
  function automatic int slice_lsb(input int width, input int n);
    return width * (N_POINTS - 1 - n);
  endfunction

endpackage

// File: rtl/fft16_frame_bank.sv
// One 16-entry complex sample bank, exposed as flattened real/imag buses
// in the layout consumed by the first butterfly stage.
module fft16_frame_bank
  import fft16_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [LOG2_N-1:0]            idx,
  input  logic [DATA_WIDTH-1:0]        wr_real,
  input  logic [DATA_WIDTH-1:0]        wr_imag,
  output logic [DATA_WIDTH*N_POINTS-1:0] flat_real,
  output logic [DATA_WIDTH*N_POINTS-1:0] flat_imag
);

  logic [DATA_WIDTH-1:0] mem_real_r [N_POINTS];
  logic [DATA_WIDTH-1:0] mem_imag_r [N_POINTS];

  // Sample storage; cleared only by reset, never on frame release.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_POINTS; i++) begin
        mem_real_r[i] <= {DATA_WIDTH{1'b0}};
        mem_imag_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (we) begin
      mem_real_r[idx] <= wr_real;
      mem_imag_r[idx] <= wr_imag;
    end else begin
      mem_real_r <= mem_real_r;
      mem_imag_r <= mem_imag_r;
    end
  end

  for (genvar n = 0; n < N_POINTS; n++) begin : g_flat
    assign flat_real[slice_lsb(DATA_WIDTH, n) +: DATA_WIDTH] = mem_real_r[n];
    assign flat_imag[slice_lsb(DATA_WIDTH, n) +: DATA_WIDTH] = mem_imag_r[n];
  end

endmodule

// File: rtl/fft16_input_loader.sv
// Streaming front end of the 16-point FFT: gathers samples into ping-pong
// frame banks and presents completed frames to the first butterfly stage.
module fft16_input_loader
  import fft16_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH-1:0]          in_real,
  input  logic [DATA_WIDTH-1:0]          in_imag,
  input  logic                           in_sof,
  output logic                           frame_valid,
  input  logic                           frame_ready,
  output logic [DATA_WIDTH*N_POINTS-1:0] x_out_flat_real,
  output logic [DATA_WIDTH*N_POINTS-1:0] x_out_flat_imag,
  output logic                           err_misalign
);

  logic [1:0]        full_r;
  logic              wr_bank_r;
  logic              rd_bank_r;
  logic [LOG2_N-1:0] wr_idx_r;

  logic [1:0]        full_next_s;
  logic              wr_bank_next_s;
  logic              rd_bank_next_s;
  logic [LOG2_N-1:0] wr_idx_next_s;

  logic              accept_s;
  logic              misalign_s;
  logic              complete_s;
  logic              take_s;
  logic [LOG2_N-1:0] wr_addr_s;

  logic [DATA_WIDTH*N_POINTS-1:0] bank0_real_s, bank0_imag_s;
  logic [DATA_WIDTH*N_POINTS-1:0] bank1_real_s, bank1_imag_s;

  assign in_ready    = !rst && !full_r[wr_bank_r];
  assign frame_valid = full_r[rd_bank_r];

  assign accept_s   = in_valid && in_ready;
  assign misalign_s = accept_s && in_sof && (wr_idx_r != 4'd0);
  // A resync start never completes a frame, even when it lands on slot 15.
  assign complete_s = accept_s && !misalign_s && (wr_idx_r == LAST_IDX);
  assign take_s     = frame_valid && frame_ready;
  assign wr_addr_s  = misalign_s ? 4'd0 : wr_idx_r;

  // Next-state for fill/drain bookkeeping; completion and release hit different banks.
  always_comb begin
    full_next_s    = full_r;
    wr_bank_next_s = wr_bank_r;
    rd_bank_next_s = rd_bank_r;
    wr_idx_next_s  = wr_idx_r;

    if (take_s) begin
      full_next_s[rd_bank_r] = 1'b0;
      rd_bank_next_s         = ~rd_bank_r;
    end else begin
      rd_bank_next_s = rd_bank_r;
    end

    if (misalign_s) begin
      wr_idx_next_s = 4'd1;
    end else if (complete_s) begin
      full_next_s[wr_bank_r] = 1'b1;
      wr_bank_next_s         = ~wr_bank_r;
      wr_idx_next_s          = 4'd0;
    end else if (accept_s) begin
      wr_idx_next_s = wr_idx_r + 4'd1;
    end else begin
      wr_idx_next_s = wr_idx_r;
    end
  end

  // Control state register and registered misalignment pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_r       <= 2'b00;
      wr_bank_r    <= 1'b0;
      rd_bank_r    <= 1'b0;
      wr_idx_r     <= 4'd0;
      err_misalign <= 1'b0;
    end else begin
      full_r       <= full_next_s;
      wr_bank_r    <= wr_bank_next_s;
      rd_bank_r    <= rd_bank_next_s;
      wr_idx_r     <= wr_idx_next_s;
      err_misalign <= misalign_s;
    end
  end

  fft16_frame_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank0 (
    .clk       (clk),
    .rst       (rst),
    .we        (accept_s && !wr_bank_r),
    .idx       (wr_addr_s),
    .wr_real   (in_real),
    .wr_imag   (in_imag),
    .flat_real (bank0_real_s),
    .flat_imag (bank0_imag_s)
  );

  fft16_frame_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank1 (
    .clk       (clk),
    .rst       (rst),
    .we        (accept_s && wr_bank_r),
    .idx       (wr_addr_s),
    .wr_real   (in_real),
    .wr_imag   (in_imag),
    .flat_real (bank1_real_s),
    .flat_imag (bank1_imag_s)
  );

  assign x_out_flat_real = rd_bank_r ? bank1_real_s : bank0_real_s;
  assign x_out_flat_imag = rd_bank_r ? bank1_imag_s : bank0_imag_s;

endmodule

// File: tb/tb_fft16_input_loader.sv
// Self-checking bench for fft16_input_loader: directed scenarios plus a
// random soak, checked against a frame-level reference model and scoreboard.
module tb_fft16_input_loader;

  localparam int W  = 20;
  localparam int BW = W * 16;

  typedef struct packed {
    logic [BW-1:0] re;
    logic [BW-1:0] im;
  } frame_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_real;
  logic [W-1:0]  in_imag;
  logic          in_sof;
  logic          frame_valid;
  logic          frame_ready;
  logic [BW-1:0] x_out_flat_real;
  logic [BW-1:0] x_out_flat_imag;
  logic          err_misalign;

  fft16_input_loader #(.DATA_WIDTH(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_real         (in_real),
    .in_imag         (in_imag),
    .in_sof          (in_sof),
    .frame_valid     (frame_valid),
    .frame_ready     (frame_ready),
    .x_out_flat_real (x_out_flat_real),
    .x_out_flat_imag (x_out_flat_imag),
    .err_misalign    (err_misalign)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: frames awaiting downstream, plus the frame being gathered.
  frame_t exp_q[$];
  frame_t part;
  int     part_n      = 0;
  bit     err_exp     = 1'b0;
  bit     armed       = 1'b0;
  bit     was_reset   = 1'b0;

  always @(negedge clk) begin
    bit exp_ready;
    bit exp_fv;
    exp_ready = !rst && (exp_q.size() < 2);
    exp_fv    = (exp_q.size() > 0);
    if (armed) begin
      check("in_ready", BW'(in_ready), BW'(exp_ready));
      check("frame_valid", BW'(frame_valid), BW'(exp_fv));
      check("err_misalign", BW'(err_misalign), BW'(err_exp));
      if (was_reset) begin
        check("reset_real_zero", x_out_flat_real, {BW{1'b0}});
        check("reset_imag_zero", x_out_flat_imag, {BW{1'b0}});
      end
      if (exp_fv) begin
        check("frame_real", x_out_flat_real, exp_q[0].re);
        check("frame_imag", x_out_flat_imag, exp_q[0].im);
      end
    end
    // Advance the model by what the coming edge will do.
    err_exp   = 1'b0;
    was_reset = rst;
    if (rst) begin
      armed  = 1'b1;
      exp_q.delete();
      part_n = 0;
    end else if (armed) begin
      if (exp_fv && frame_ready) void'(exp_q.pop_front());
      if (in_valid && exp_ready) begin
        if (in_sof && part_n != 0) begin
          part_n  = 0;
          err_exp = 1'b1;
        end
        if (part_n == 0) part = '0;
        part.re = (part.re << W) | BW'(in_real);
        part.im = (part.im << W) | BW'(in_imag);
        part_n++;
        if (part_n == 16) begin
          exp_q.push_back(part);
          part_n = 0;
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] re, input logic [W-1:0] im, input logic sof,
                      input int max_wait, output bit acc);
    in_valid = 1'b1;
    in_real  = re;
    in_imag  = im;
    in_sof   = sof;
    acc      = 1'b0;
    for (int k = 0; k < max_wait && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int n_acc;
    logic [W-1:0] first_b1;

    rst = 1'b1; in_valid = 1'b0; in_real = '0; in_imag = '0; in_sof = 1'b0; frame_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;

    // Ramp frame: real=n, imag=-n.
    frame_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      send(W'(n), W'(-n), (n == 0), 1, acc);
      check("ramp_accept", BW'(acc), BW'(1'b1));
    end
    check("ramp_fv", BW'(frame_valid), BW'(1'b1));
    check("ramp_s0_real", BW'(x_out_flat_real[319:300]), BW'(0));
    check("ramp_s15_real", BW'(x_out_flat_real[19:0]), BW'(15));
    check("ramp_s15_imag", BW'(x_out_flat_imag[19:0]), BW'(20'hFFFF1));
    idle(3);

    // Backpressure: 40 samples offered with frame_ready low.
    frame_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 40; i++) begin
      send(W'(1000 + i), W'($urandom), (i % 16 == 0), 2, acc);
      if (acc) n_acc++;
    end
    check("bp_accepted", BW'(n_acc), BW'(32));
    check("bp_ready_low", BW'(in_ready), BW'(1'b0));
    frame_ready = 1'b1;
    @(posedge clk); #1;
    frame_ready = 1'b0;
    check("bp_next_frame_s0", BW'(x_out_flat_real[319:300]), BW'(1016));
    check("bp_ready_back", BW'(in_ready), BW'(1'b1));
    idle(3);
    frame_ready = 1'b1;
    for (int i = 32; i < 48; i++) begin
      send(W'(1000 + i), W'($urandom), (i == 32), 4, acc);
      check("bp_resume_accept", BW'(acc), BW'(1'b1));
    end
    idle(4);

    // Misaligned start-of-frame after 5 samples.
    for (int i = 0; i < 5; i++) send(W'(50 + i), W'($urandom), (i == 0), 2, acc);
    send(W'(100), W'(7), 1'b1, 2, acc);
    check("mis_err_pulse", BW'(err_misalign), BW'(1'b1));
    for (int i = 0; i < 15; i++) send(W'(101 + i), W'($urandom), 1'b0, 2, acc);
    check("mis_fv", BW'(frame_valid), BW'(1'b1));
    check("mis_s0_real", BW'(x_out_flat_real[319:300]), BW'(100));
    idle(3);

    // Continuous stream, 64 samples.
    for (int i = 0; i < 64; i++) begin
      send(W'($urandom), W'($urandom), (i % 16 == 0), 1, acc);
      check("stream_ready", BW'(acc), BW'(1'b1));
    end
    idle(3);

    // Reset in the middle of a frame.
    for (int i = 0; i < 7; i++) send(W'($urandom), W'($urandom), (i == 0), 2, acc);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", BW'(in_ready), BW'(1'b0));
    check("rst_fv", BW'(frame_valid), BW'(1'b0));
    check("rst_real", x_out_flat_real, {BW{1'b0}});
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) send(W'(300 + i), W'($urandom), (i == 0), 2, acc);
    check("post_rst_fv", BW'(frame_valid), BW'(1'b1));
    check("post_rst_s0", BW'(x_out_flat_real[319:300]), BW'(300));
    idle(3);

    // Completion of one bank in the same edge as release of the other.
    frame_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(W'(500 + i), W'($urandom), (i == 0), 2, acc);
    first_b1 = W'(600);
    for (int i = 0; i < 15; i++) send(first_b1 + W'(i), W'($urandom), (i == 0), 2, acc);
    frame_ready = 1'b1;
    send(first_b1 + W'(15), W'(1), 1'b0, 1, acc);
    check("sim_accept", BW'(acc), BW'(1'b1));
    check("sim_fv", BW'(frame_valid), BW'(1'b1));
    check("sim_s0", BW'(x_out_flat_real[319:300]), BW'(first_b1));
    idle(3);

    // Random soak with random backpressure and occasional stray start-of-frame.
    for (int c = 0; c < 400; c++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      frame_ready = ($urandom_range(0, 2) != 0);
      in_sof      = ($urandom_range(0, 19) == 0);
      in_real     = W'($urandom);
      in_imag     = W'($urandom);
      @(posedge clk); #1;
    end
    frame_ready = 1'b1;
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
